alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; legal values 8, 16, 32.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width; not overridden independently.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 in_valid  input  1: operation request.
REQ-006 in_ready  output  1: unit can accept a request.
REQ-007 op  input  4: opcode. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 SLL, 7 ROL, 8 SRL, 9 SRA, 10 MUL, 11 DIV; 12-15 illegal.
REQ-008 a, b  input  WIDTH: operands; MOV uses a only; shifts use a and the amount b[SHW-1:0].
REQ-009 out_valid  output  1: result available.
REQ-010 out_ready  input  1: consumer accepts the result.
REQ-011 result  output  WIDTH: primary result, which is the quotient for DIV.
REQ-012 rem  output  WIDTH: DIV remainder; 0 for all other ops.
REQ-013 S, V, Z, C  output  1 each: sign, overflow, zero and carry flags.
REQ-014 err  output  1: illegal opcode or divide-by-zero.

Function
REQ-015 FSM states are IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Accept occurs on the edge where in_valid && in_ready; op, a and b are captured on that edge.
REQ-017 Ops 0-9, illegal ops and DIV with b==0 go IDLE->DONE on the accept edge: out_valid is high 1 cycle after accept.
REQ-018 MUL/DIV with b!=0 go IDLE->CALC and iterate exactly WIDTH cycles, one bit per cycle; CALC->DONE on the WIDTH-th edge after accept.
REQ-019 DONE->IDLE on the edge where out_ready is high; result, rem, flags and err are held stable while out_valid && !out_ready.
REQ-020 There is no new accept in the DONE cycle; the next accept is earliest 1 cycle after the DONE->IDLE edge.
REQ-021 ADD: C = carry out of bit WIDTH-1; V = two's-complement signed overflow.
REQ-022 SUB (a-b): C = borrow (a<b unsigned); V = signed overflow.
REQ-023 AND, OR, XOR, MOV, ROL: C=0, V=0.
REQ-024 ROL is a left rotate by amount.
REQ-025 SLL, SRL and SRA zero/sign fill; C = last bit shifted out; C=0 when amount is 0.
REQ-026 MUL: unsigned shift-add; result = low WIDTH bits; C = V = (high WIDTH bits != 0).
REQ-027 DIV: unsigned restoring division; result = quotient, rem = remainder; C=0, V=0.
REQ-028 DIV with b==0: result all ones, rem = a, V=1, err=1.
REQ-029 For all ops: S = result[WIDTH-1]; Z = (result==0).
REQ-030 Illegal opcode: result = 0, rem = 0, S=V=C=0, Z=1, err=1.
REQ-031 in_valid while not in_ready is ignored; the request is not queued.

Reset
REQ-032 Reset forces state=IDLE and iteration counter=0; result, rem, S, V, C and err = 0; Z=1.
REQ-033 Reset asserted in CALC or DONE aborts the operation with no output; in_ready is 1 in the first cycle after deassertion.

Structure
REQ-034 Package alu_pkg holds: opcode constants, default WIDTH, and flag bit positions (S=0, V=1, Z=2, C=3) for packing {C,Z,V,S,result}.
REQ-035 Sub-module alu_seq_comb is combinational ops 0-9 plus flags, parameterised by WIDTH; MUL/DIV iteration and the FSM live in alu_seq.

Verification (WIDTH=16)
REQ-036 ADD a=0x7FFF, b=0x0001 -> 1 cycle later out_valid, result 0x8000, S=1, V=1, C=0, Z=0.
REQ-037 SUB a=0x0000, b=0x0001 -> result 0xFFFF, C=1, S=1, V=0; SRA a=0x8001, b=1 -> 0xC000, C=1.
REQ-038 MUL a=0x0100, b=0x0100 -> out_valid exactly 16 cycles after accept, result 0x0000, Z=1, C=1, V=1; in_ready=0 throughout.
REQ-039 DIV a=100, b=7 -> result 14, rem 2 after 16 cycles; DIV a=5, b=0 -> 1 cycle, result 0xFFFF, rem 5, V=1, err=1.
REQ-040 Hold out_ready=0 for 3 cycles after out_valid -> outputs unchanged; in_valid pulses during that time are ignored.
REQ-041 Assert reset at cycle 5 of a MUL -> after deassertion in_ready=1, out_valid=0 and no result is ever produced; a following op 13 -> err=1, Z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, default width
// and the bit positions used when packing {C,Z,V,S,result}.
package alu_pkg;

    localparam int unsigned ALU_WIDTH_DEF = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_MOV = 4'd5,
        OP_SLL = 4'd6,
        OP_ROL = 4'd7,
        OP_SRL = 4'd8,
        OP_SRA = 4'd9,
        OP_MUL = 4'd10,
        OP_DIV = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } alu_state_e;

    localparam int unsigned FLAG_S = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 3;

    function automatic logic [3:0] pack_flags(input logic s, input logic v,
                                              input logic z, input logic c);
        logic [3:0] f;
        f         = '0;
        f[FLAG_S] = s;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between an ALU client (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rem;
    logic             S;
    logic             V;
    logic             Z;
    logic             C;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, rem, S, V, Z, C, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, rem, S, V, Z, C, err
    );
endinterface

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU operations (opcodes 0-9) with their S/V/Z/C flags.
module alu_seq_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEF,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags
);

    logic [SHW-1:0]   w_amt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH:0]   w_sll;
    logic [WIDTH:0]   w_srl;
    logic [WIDTH:0]   w_sra;
    logic [WIDTH-1:0] w_rol;
    logic             w_c;
    logic             w_v;

    assign w_amt  = i_b[SHW-1:0];
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = i_a - i_b;
    // One guard bit beside the operand catches the last bit shifted out
    // and is naturally zero when the amount is zero.
    assign w_sll  = {1'b0, i_a} << w_amt;
    assign w_srl  = {i_a, 1'b0} >> w_amt;
    assign w_sra  = $unsigned($signed({i_a, 1'b0}) >>> w_amt);
    assign w_rol  = (i_a << w_amt) | (i_a >> (WIDTH - 32'(w_amt)));

    always_comb begin
        o_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_result = w_diff;
                w_c      = (i_a < i_b);
                w_v      = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_MOV: o_result = i_a;
            OP_SLL: begin
                o_result = w_sll[WIDTH-1:0];
                w_c      = w_sll[WIDTH];
            end
            OP_ROL: o_result = w_rol;
            OP_SRL: begin
                o_result = w_srl[WIDTH:1];
                w_c      = w_srl[0];
            end
            OP_SRA: begin
                o_result = w_sra[WIDTH:1];
                w_c      = w_sra[0];
            end
            default: ;
        endcase
    end

    assign o_flags = pack_flags(o_result[WIDTH-1], w_v, (o_result == '0), w_c);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops via alu_seq_comb, bit-serial MUL/DIV over
// WIDTH cycles, IDLE/CALC/DONE handshake with results held until accepted.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEF,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);

    alu_state_e       r_state;
    alu_state_e       w_state_nxt;
    logic [SHW-1:0]   r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_rem;
    logic [3:0]       r_flags;
    logic             r_err;

    logic             w_accept;
    logic             w_long;
    logic             w_last;
    logic             w_illegal;
    logic [WIDTH-1:0] w_comb_result;
    logic [3:0]       w_comb_flags;
    logic [WIDTH:0]   w_msum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_rsh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_div_r;
    logic [WIDTH-1:0] w_div_q;

    alu_seq_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .i_op     (bus.op),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_result (w_comb_result),
        .o_flags  (w_comb_flags)
    );

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_long    = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0));
    assign w_illegal = (bus.op > OP_DIV);
    assign w_last    = (r_cnt == SHW'(WIDTH - 1));

    // Multiply: r_hi holds the partial product, r_lo the multiplier shifting
    // out LSB-first while product bits shift in from the top.
    assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_hi = w_msum[WIDTH:1];
    assign w_mul_lo = {w_msum[0], r_lo[WIDTH-1:1]};

    // Divide: r_hi is the partial remainder, r_lo the dividend turning into
    // the quotient; a negative trial keeps (restores) the shifted remainder.
    assign w_rsh   = {r_hi, r_lo[WIDTH-1]};
    assign w_trial = w_rsh - {1'b0, r_opnd};
    assign w_div_r = w_trial[WIDTH] ? w_rsh[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_div_q = {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= ((r_state == ST_CALC) && !w_last) ? r_cnt + SHW'(1) : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_long ? ST_CALC : ST_DONE;
            ST_CALC: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_rem    <= '0;
            r_flags  <= pack_flags(1'b0, 1'b0, 1'b1, 1'b0);
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_is_div <= (bus.op == OP_DIV);
            r_hi     <= '0;
            r_lo     <= (bus.op == OP_DIV) ? bus.a : bus.b;
            r_opnd   <= (bus.op == OP_DIV) ? bus.b : bus.a;
            if (w_illegal) begin
                r_result <= '0;
                r_rem    <= '0;
                r_flags  <= pack_flags(1'b0, 1'b0, 1'b1, 1'b0);
                r_err    <= 1'b1;
            end else if ((bus.op == OP_DIV) && (bus.b == '0)) begin
                r_result <= '1;
                r_rem    <= bus.a;
                r_flags  <= pack_flags(1'b1, 1'b1, 1'b0, 1'b0);
                r_err    <= 1'b1;
            end else if (!w_long) begin
                r_result <= w_comb_result;
                r_rem    <= '0;
                r_flags  <= w_comb_flags;
                r_err    <= 1'b0;
            end
        end else if (r_state == ST_CALC) begin
            r_hi <= r_is_div ? w_div_r : w_mul_hi;
            r_lo <= r_is_div ? w_div_q : w_mul_lo;
            if (w_last) begin
                r_err <= 1'b0;
                if (r_is_div) begin
                    r_result <= w_div_q;
                    r_rem    <= w_div_r;
                    r_flags  <= pack_flags(w_div_q[WIDTH-1], 1'b0, (w_div_q == '0), 1'b0);
                end else begin
                    r_result <= w_mul_lo;
                    r_rem    <= '0;
                    r_flags  <= pack_flags(w_mul_lo[WIDTH-1], (w_mul_hi != '0),
                                           (w_mul_lo == '0), (w_mul_hi != '0));
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.rem       = r_rem;
    assign bus.S         = r_flags[FLAG_S];
    assign bus.V         = r_flags[FLAG_V];
    assign bus.Z         = r_flags[FLAG_Z];
    assign bus.C         = r_flags[FLAG_C];
    assign bus.err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed corner cases, randomized
// ops against an arithmetic reference model, output hold and reset abort.
module tb_alu_seq;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packed view {result, rem, S, V, Z, C, err}
    function automatic logic [36:0] dut_out();
        return {bus.result, bus.rem, bus.S, bus.V, bus.Z, bus.C, bus.err};
    endfunction

    function automatic logic [36:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] res, rm, r;
        logic [16:0] full;
        logic [31:0] p;
        logic        v, c, e;
        int          sa, sb, si, amt;
        res = '0; rm = '0; v = 0; c = 0; e = 0;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        amt = int'(b[3:0]);
        case (op)
            4'd0: begin
                full = {1'b0, a} + {1'b0, b};
                res = full[15:0]; c = full[16];
                si = sa + sb; v = (si > 32767) || (si < -32768);
            end
            4'd1: begin
                res = a - b; c = (a < b);
                si = sa - sb; v = (si > 32767) || (si < -32768);
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = a;
            4'd6: begin res = a << amt; c = (amt != 0) ? a[16 - amt] : 1'b0; end
            4'd7: begin
                r = a;
                for (int i = 0; i < amt; i++) r = {r[14:0], r[15]};
                res = r;
            end
            4'd8: begin res = a >> amt; c = (amt != 0) ? a[amt - 1] : 1'b0; end
            4'd9: begin res = 16'($signed(a) >>> amt); c = (amt != 0) ? a[amt - 1] : 1'b0; end
            4'd10: begin
                p = 32'(a) * 32'(b);
                res = p[15:0]; c = (p[31:16] != 0); v = c;
            end
            4'd11: begin
                if (b == 0) begin res = 16'hFFFF; rm = a; v = 1; e = 1; end
                else begin res = a / b; rm = a % b; end
            end
            default: e = 1;
        endcase
        return {res, rm, res[15], v, (res == 0), c, e};
    endfunction

    // Drives one request, waits for out_valid; lat = edges after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [36:0] obs, output int lat, output bit busy_ok);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        obs = dut_out();
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_bad++; $display("FAIL reset_hs: got rdy/vld=%b want 10", {bus.in_ready, bus.out_valid});
        end
        n_cmp++;
        if (dut_out() !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_out: got %h want %h", dut_out(), {32'h0, 5'b00100});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_rdy: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [36:0] obs;
        int          lat;
        bit          busy;
        logic [3:0]  ops  [6] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd11, 4'd11};
        logic [15:0] as   [6] = '{16'h7FFF, 16'h0000, 16'h8001, 16'h0100, 16'd100, 16'd5};
        logic [15:0] bs   [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0100, 16'd7, 16'd0};
        int          lats [6] = '{0, 0, 0, 16, 16, 0};
        logic [36:0] exps [6] = '{
            {16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            {16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            {16'hC000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            {16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            {16'd14,   16'd2,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            {16'hFFFF, 16'd5,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], obs, lat, busy);
            n_cmp++;
            if (lat != lats[i]) begin
                n_bad++; $display("FAIL dir_lat[%0d]: got %0d want %0d", i, lat, lats[i]);
            end
            n_cmp++;
            if (obs !== exps[i]) begin
                n_bad++; $display("FAIL dir_out[%0d]: got %h want %h", i, obs, exps[i]);
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++; $display("FAIL dir_busy[%0d]: in_ready rose before out_valid", i);
            end
            release_result();
        end
    endtask

    task automatic test_random_ops();
        logic [36:0] obs, exp;
        logic [3:0]  op;
        logic [15:0] a, b;
        int          lat, want_lat;
        bit          busy;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 4) == 0) a = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
            if (op == 4'd11 && $urandom_range(0, 3) == 0) b = '0;
            if (op >= 4'd6 && op <= 4'd9 && $urandom_range(0, 3) == 0) b = 16'h0000;
            exp      = model(op, a, b);
            want_lat = (op == 4'd10 || (op == 4'd11 && b != 0)) ? 16 : 0;
            issue(op, a, b, obs, lat, busy);
            n_cmp++;
            if (lat != want_lat) begin
                n_bad++; $display("FAIL rnd_lat op=%0d: got %0d want %0d", op, lat, want_lat);
            end
            n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL rnd_out op=%0d a=%h b=%h: got %h want %h", op, a, b, obs, exp);
            end
            release_result();
        end
    endtask

    task automatic test_hold();
        logic [36:0] obs, exp;
        int          lat;
        bit          busy;
        logic [15:0] a, b;
        a = 16'($urandom); b = 16'($urandom);
        exp = model(4'd0, a, b);
        issue(4'd0, a, b, obs, lat, busy);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL hold_first: got %h want %h", obs, exp);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.op = 4'd5; bus.a = 16'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (dut_out() !== exp) begin
                n_bad++; $display("FAIL hold_out[%0d]: got %h want %h", i, dut_out(), exp);
            end
            n_cmp++;
            if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
                n_bad++; $display("FAIL hold_hs[%0d]: got rdy/vld=%b want 01", i, {bus.in_ready, bus.out_valid});
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                n_bad++; $display("FAIL hold_noqueue[%0d]: got rdy/vld=%b want 10", i, {bus.in_ready, bus.out_valid});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        logic [36:0] obs;
        int          lat;
        bit          busy;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd10; bus.a = 16'h0100; bus.b = 16'h0100;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
            n_bad++; $display("FAIL abort_busy: got rdy/vld=%b want 00", {bus.in_ready, bus.out_valid});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_bad++; $display("FAIL abort_hs: got rdy/vld=%b want 10", {bus.in_ready, bus.out_valid});
        end
        n_cmp++;
        if (dut_out() !== {32'h0, 5'b00100}) begin
            n_bad++; $display("FAIL abort_out: got %h want %h", dut_out(), {32'h0, 5'b00100});
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++; $display("FAIL abort_novalid[%0d]: got out_valid=%b want 0", i, bus.out_valid);
            end
        end
        issue(4'd13, 16'($urandom), 16'($urandom), obs, lat, busy);
        n_cmp++;
        if (lat != 0) begin
            n_bad++; $display("FAIL illegal_lat: got %0d want 0", lat);
        end
        n_cmp++;
        if (obs !== {32'h0, 5'b00101}) begin
            n_bad++; $display("FAIL illegal_out: got %h want %h", obs, {32'h0, 5'b00101});
        end
        release_result();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_random_ops();
        test_hold();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
